// File: rtl/lif_pkg.sv
// Shared constants and types for the LIF neuron array.
// Optional build macro LIF_ADAPT_EN enables per-channel threshold adaptation.
package lif_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int W_DEF     = 8;
  localparam int RW_DEF    = 4;
  localparam int CNT_W_DEF = 16;

  // Adaptation step is 2^(W-ADAPT_SHIFT), i.e. one eighth of full scale.
  localparam int ADAPT_SHIFT = 3;

  typedef struct packed {
    logic [W_DEF-1:0]  mem;
    logic [RW_DEF-1:0] rc;
  } lif_state_t;

  function automatic int adapt_inc(input int w);
    return 1 << (w - ADAPT_SHIFT);
  endfunction

endpackage

// File: rtl/lif_core.sv
// Single leaky integrate-and-fire channel: membrane state, refractory counter,
// registered spike, plus an adaptive threshold offset when LIF_ADAPT_EN is defined.
module lif_core
  import lif_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [W-1:0]  current,
  input  logic [W-1:0]  thresh,
  input  logic [2:0]    leak_sh,
  input  logic [RW-1:0] refrac,
  output logic [W-1:0]  state,
  output logic          spike,
  output logic          spike_nxt
);

  localparam logic [W-1:0] MAX_V = '1;

  logic [W-1:0]  state_q, state_d;
  logic [RW-1:0] rc_q, rc_d;
  logic          spike_q, spike_d;
  logic [W-1:0]  leaked;
  logic [W:0]    sum_raw;
  logic [W-1:0]  sum_sat;
  logic [W-1:0]  eff_th;

`ifdef LIF_ADAPT_EN
  localparam logic [W:0] INC = (W+1)'(adapt_inc(W));

  logic [W-1:0] offset_q, offset_d;
  logic [W:0]   th_raw;
  logic [W:0]   off_raw;

  always_comb begin
    th_raw   = {1'b0, thresh} + {1'b0, offset_q};
    eff_th   = th_raw[W] ? MAX_V : th_raw[W-1:0];
    off_raw  = {1'b0, offset_q} + INC;
    offset_d = offset_q;
    if (tick) begin
      if (spike_d)
        offset_d = off_raw[W] ? MAX_V : off_raw[W-1:0];
      else if (offset_q != '0)
        offset_d = offset_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) offset_q <= '0;
    else        offset_q <= offset_d;
  end
`else
  assign eff_th = thresh;
`endif

  // A zero shift subtracts the whole state, giving full decay for free.
  always_comb begin
    leaked  = state_q - (state_q >> leak_sh);
    sum_raw = {1'b0, leaked} + {1'b0, current};
    sum_sat = sum_raw[W] ? MAX_V : sum_raw[W-1:0];
    state_d = state_q;
    rc_d    = rc_q;
    spike_d = 1'b0;
    if (tick) begin
      if (rc_q != '0) begin
        rc_d    = rc_q - 1'b1;
        state_d = '0;
      end else if (sum_sat >= eff_th) begin
        spike_d = 1'b1;
        state_d = '0;
        rc_d    = refrac;
      end else begin
        state_d = sum_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rc_q    <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      spike_q <= spike_d;
    end
  end

  assign state     = state_q;
  assign spike     = spike_q;
  assign spike_nxt = spike_d;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_CH LIF channels sharing tick and configuration, with aggregate
// spike flag and wrapping spike counter. LIF_ADAPT_EN enables adaptive thresholds.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int W     = W_DEF,
  parameter int RW    = RW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [N_CH*W-1:0] current,
  input  logic [W-1:0]      thresh,
  input  logic [2:0]        leak_sh,
  input  logic [RW-1:0]     refrac,
  output logic [N_CH*W-1:0] state_out,
  output logic [N_CH-1:0]   spike,
  output logic              spike_any,
  output logic [CNT_W-1:0]  spike_cnt
);

  logic [N_CH-1:0]  spike_nxt;
  logic [CNT_W-1:0] pop;
  logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
  logic             spike_any_q, spike_any_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    lif_core #(.W(W), .RW(RW)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .current   (current[k*W +: W]),
      .thresh    (thresh),
      .leak_sh   (leak_sh),
      .refrac    (refrac),
      .state     (state_out[k*W +: W]),
      .spike     (spike[k]),
      .spike_nxt (spike_nxt[k])
    );
  end

  // Aggregates use the channels' next spikes so they line up with the spike flops.
  always_comb begin
    pop = '0;
    for (int k = 0; k < N_CH; k++)
      pop = pop + CNT_W'(spike_nxt[k]);
    spike_cnt_d = spike_cnt_q + pop;
    spike_any_d = |spike_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_cnt_q <= '0;
      spike_any_q <= 1'b0;
    end else begin
      spike_cnt_q <= spike_cnt_d;
      spike_any_q <= spike_any_d;
    end
  end

  assign spike_cnt = spike_cnt_q;
  assign spike_any = spike_any_q;

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Parametrised array of N_CH leaky integrate-and-fire neurons with a common tick, runtime-programmable threshold, leak shift and refractory period. Successor to the fixed two-neuron LIF pair: arbitrary channel count and state width, refractory behaviour, saturating integration and an aggregate spike counter. Sits between the pad-level input currents and the TinyTapeout top-level output mapping.

Parameters:
N_CH, 4, number of neuron channels (1..8)
W, 8, membrane state and input current width in bits
RW, 4, refractory counter width in bits
CNT_W, 16, aggregate spike counter width in bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  update strobe; neurons integrate only on cycles with tick=1
current  in  N_CH*W  per-channel input current, channel k in bits [k*W +: W]
thresh  in  W  firing threshold (unsigned)
leak_sh  in  3  leak shift amount
refrac  in  RW  refractory length in ticks
state_out  out  N_CH*W  per-channel membrane state, same packing as current
spike  out  N_CH  per-channel spike, one-cycle pulse
spike_any  out  1  OR of spike
spike_cnt  out  CNT_W  running total of spikes, all channels

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. On reset, all states, refractory counters, spike, spike_any and spike_cnt are 0.
- All outputs are registered. The effect of a tick on cycle t is visible at cycle t+1.
- tick=0: state and refractory counter hold; spike=0, spike_any=0.
- tick=1, channel with rc>0 (refractory): rc<=rc-1; state<=0; spike=0; current is ignored.
- tick=1, channel with rc=0:
  - leaked = state - (state >> leak_sh). leak_sh=0 means full decay, so leaked=0.
  - sum = leaked + current, computed at W+1 bits and saturated to 2^W-1.
  - If sum >= thresh: spike=1, state<=0, rc<=refrac.
  - Otherwise: state<=sum, spike=0.
- thresh=0: every non-refractory tick fires.
- refrac=0: no refractory period; the channel may fire on consecutive ticks.
- thresh, leak_sh and refrac are sampled on each tick. Mid-run changes apply from the next tick with no other side effects.
- spike_any = OR of the registered spike bits, registered in the same cycle as spike.
- spike_cnt: on each tick, spike_cnt <= spike_cnt + popcount(new spikes). Wraps modulo 2^CNT_W.
- Reset asserted mid-refractory or mid-integration clears everything immediately. There is no pending state after release.

Optional Feature:
LIF_ADAPT_EN
- Defined:
  - Each channel keeps a W-bit adaptation offset.
  - On a spike, offset += 2^(W-3), saturating at 2^W-1.
  - On each non-spiking tick, offset decrements by 1 if nonzero.
  - Effective threshold = min(thresh + offset, 2^W-1).
  - Offset resets to 0.
- Undefined: no offset registers; effective threshold = thresh.

Decomposition:
- Shared package lif_pkg holds:
  - default parameter constants: N_CH, W, RW, CNT_W
  - the typedef for per-channel state
  - the adaptation increment constant
- One sub-module, lif_core: a single channel holding state, refractory counter, optional offset and spike bit. It is instantiated N_CH times via generate.
- Popcount and spike counter live in lif_neuron_array.

Test Plan:
- Reset -> state_out=0, spike=0, spike_cnt=0. Assert rst_n low mid-refractory -> all zero on the same cycle, and ch0 integrates normally after release.
- Integration and refractory (ch0, current=120, thresh=200, leak_sh=1, refrac=2, tick every cycle):
  - states 120, 180, then spike on tick 3 with state 0.
  - next 2 ticks state 0 with no spike; tick 6 state 120.
- Slow approach (current=100, thresh=200, leak_sh=1): states 100, 150, 175, 188, 194, 197, 199, then spike on tick 8.
- Saturation (leak_sh=7, thresh=255, current=200): 200, then 199+200 saturates to 255 -> spike on tick 2.
- Gating (tick=0 for 5 cycles with current=50) -> state holds, spike=0, spike_cnt unchanged.
- All 4 channels (current=255, thresh=10, refrac=0) -> spike=4'hF and spike_any=1 every tick; spike_cnt increments by 4 per tick and wraps 65532 -> 0.
